// File: rtl/pwm_ctrl_pkg.sv
// Shared types and helpers for the PWM duty controller.
package pwm_ctrl_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StHoldUp,
        StHoldDn,
        StRptUp,
        StRptDn
    } pwm_state_e;

    function automatic int unsigned CLKS_PER_MS(input int unsigned freq_mhz);
        return freq_mhz * 1000;
    endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// Millisecond tick generator: one-cycle pulse every FREQ*1000 clocks, restartable via clr.
module ms_tick_gen
    import pwm_ctrl_pkg::*;
#(
    parameter int unsigned FREQ = 50
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    localparam int unsigned Clks = CLKS_PER_MS(FREQ);
    localparam int unsigned CntW = (Clks > 1) ? $clog2(Clks) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(Clks - 1);

    logic [CntW-1:0] cnt_d, cnt_q;

    // tick depends only on the count so the owner may derive clr from it without a loop
    always_comb begin
        tick  = (cnt_q == CntLast);
        cnt_d = cnt_q + CntW'(1);
        if (clr || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/pwm_duty_ctrl.sv
// PWM duty controller: up/down keys step the duty with saturation and optional hold auto-repeat.
// Auto-repeat (ms timebase, RPT states) is built only when PWM_CTRL_AUTOREPEAT_EN is defined.
module pwm_duty_ctrl
    import pwm_ctrl_pkg::*;
#(
    parameter int unsigned FREQ      = 50,
    parameter int unsigned DW        = 8,
    parameter int unsigned DUTY_MAX  = 255,
    parameter int unsigned DUTY_INIT = 128,
    parameter int unsigned STEP      = 8,
    parameter int unsigned HOLD_MS   = 500,
    parameter int unsigned REPEAT_MS = 100
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          up_press,
    input  logic          up_level,
    input  logic          dn_press,
    input  logic          dn_level,
    output logic [DW-1:0] duty,
    output logic          duty_upd,
    output logic          at_max,
    output logic          at_min
);

    localparam logic [DW:0]   StepW    = (DW + 1)'(STEP);
    localparam logic [DW:0]   DutyMaxW = (DW + 1)'(DUTY_MAX);
    localparam logic [DW-1:0] DutyMax  = DW'(DUTY_MAX);
    localparam logic [DW-1:0] DutyInit = DW'(DUTY_INIT);

    // Sum is one bit wider than the duty so a step near the top cannot wrap.
    function automatic logic [DW-1:0] step_up(input logic [DW-1:0] d);
        logic [DW:0] sum;
        sum = {1'b0, d} + StepW;
        return (sum > DutyMaxW) ? DutyMax : sum[DW-1:0];
    endfunction

    function automatic logic [DW-1:0] step_dn(input logic [DW-1:0] d);
        return ({1'b0, d} < StepW) ? '0 : (d - StepW[DW-1:0]);
    endfunction

    pwm_state_e    state_d, state_q;
    logic [DW-1:0] duty_d, duty_q;
    logic          duty_upd_d, duty_upd_q;
    logic          at_max_d, at_max_q;
    logic          at_min_d, at_min_q;
    logic          do_up, do_dn;
    logic          tmr_clr;
    logic          hold_done, rpt_done;

`ifdef PWM_CTRL_AUTOREPEAT_EN
    localparam int unsigned MsMax = (HOLD_MS > REPEAT_MS) ? HOLD_MS : REPEAT_MS;
    localparam int unsigned MsW   = (MsMax > 1) ? $clog2(MsMax) : 1;

    logic           ms_tick;
    logic [MsW-1:0] ms_d, ms_q;

    ms_tick_gen #(
        .FREQ(FREQ)
    ) u_ms_tick_gen (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (tmr_clr),
        .tick (ms_tick)
    );

    assign hold_done = ms_tick && (ms_q == MsW'(HOLD_MS - 1));
    assign rpt_done  = ms_tick && (ms_q == MsW'(REPEAT_MS - 1));

    // Free-running wrap in IDLE is harmless: every HOLD/RPT entry clears it.
    always_comb begin
        ms_d = ms_q;
        if (tmr_clr) begin
            ms_d = '0;
        end else if (ms_tick) begin
            ms_d = ms_q + MsW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ms_q <= '0;
        end else begin
            ms_q <= ms_d;
        end
    end
`else
    logic unused_timing;

    assign hold_done     = 1'b0;
    assign rpt_done      = 1'b0;
    assign unused_timing = ^{tmr_clr, 32'(FREQ), 32'(HOLD_MS), 32'(REPEAT_MS)};
`endif

    always_comb begin
        state_d = state_q;
        do_up   = 1'b0;
        do_dn   = 1'b0;
        tmr_clr = 1'b0;
        duty_d  = duty_q;

        unique case (state_q)
            StIdle: begin
                if (up_press && dn_press) begin
                    duty_d = DutyInit;
                end else if (up_press) begin
                    do_up   = 1'b1;
                    tmr_clr = 1'b1;
                    state_d = StHoldUp;
                end else if (dn_press) begin
                    do_dn   = 1'b1;
                    tmr_clr = 1'b1;
                    state_d = StHoldDn;
                end
            end
            StHoldUp: begin
                if (up_level) begin
                    state_d = StIdle;
                end else if (hold_done) begin
                    do_up   = 1'b1;
                    tmr_clr = 1'b1;
                    state_d = StRptUp;
                end
            end
            StHoldDn: begin
                if (dn_level) begin
                    state_d = StIdle;
                end else if (hold_done) begin
                    do_dn   = 1'b1;
                    tmr_clr = 1'b1;
                    state_d = StRptDn;
                end
            end
            StRptUp: begin
                if (up_level) begin
                    state_d = StIdle;
                end else if (rpt_done) begin
                    do_up   = 1'b1;
                    tmr_clr = 1'b1;
                end
            end
            StRptDn: begin
                if (dn_level) begin
                    state_d = StIdle;
                end else if (rpt_done) begin
                    do_dn   = 1'b1;
                    tmr_clr = 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (do_up) begin
            duty_d = step_up(duty_q);
        end else if (do_dn) begin
            duty_d = step_dn(duty_q);
        end

        duty_upd_d = (duty_d != duty_q);
        at_max_d   = (duty_d == DutyMax);
        at_min_d   = (duty_d == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            duty_q     <= DutyInit;
            duty_upd_q <= 1'b0;
            at_max_q   <= (DutyInit == DutyMax);
            at_min_q   <= (DutyInit == '0);
        end else begin
            state_q    <= state_d;
            duty_q     <= duty_d;
            duty_upd_q <= duty_upd_d;
            at_max_q   <= at_max_d;
            at_min_q   <= at_min_d;
        end
    end

    assign duty     = duty_q;
    assign duty_upd = duty_upd_q;
    assign at_max   = at_max_q;
    assign at_min   = at_min_q;

endmodule

// File: doc/pwm_duty_ctrl.md
PWM_DUTY_CTRL -- requirements
Module: pwm_duty_ctrl

Interface
REQ-001 SHALL have parameter FREQ, default 50, module clock in MHz.
REQ-002 SHALL have parameter DW, default 8, duty width in bits.
REQ-003 SHALL have parameter DUTY_MAX, default 255, upper duty limit.
REQ-004 SHALL have parameter DUTY_INIT, default 128, reset and recentre duty.
REQ-005 SHALL have parameter STEP, default 8, duty increment per step.
REQ-006 SHALL have parameter HOLD_MS, default 500, press time before auto-repeat starts.
REQ-007 SHALL have parameter REPEAT_MS, default 100, auto-repeat period.
REQ-008 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-009 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-010 SHALL have port up_press, input, 1 bit: one-cycle pulse, debounced up key pressed (key_negedge).
REQ-011 SHALL have port up_level, input, 1 bit: debounced up key level, 0 = held.
REQ-012 SHALL have port dn_press, input, 1 bit: one-cycle pulse, debounced down key pressed.
REQ-013 SHALL have port dn_level, input, 1 bit: debounced down key level, 0 = held.
REQ-014 SHALL have port duty, output, DW bits: current PWM duty.
REQ-015 SHALL have port duty_upd, output, 1 bit: one-cycle pulse when duty changes.
REQ-016 SHALL have ports at_max and at_min, output, 1 bit each: duty==DUTY_MAX and duty==0.

Function
REQ-017 SHALL implement FSM with states IDLE, HOLD_UP, HOLD_DN, RPT_UP, RPT_DN.
REQ-018 In IDLE, up_press alone SHALL step duty up and enter HOLD_UP; dn_press alone SHALL step down and enter HOLD_DN.
REQ-019 Step latency SHALL be one cycle: press pulse in cycle N gives new duty and duty_upd in cycle N+1.
REQ-020 Up step SHALL saturate: duty = min(duty+STEP, DUTY_MAX), computed DW+1 bits wide to prevent wrap.
REQ-021 Down step SHALL saturate: duty = (duty<STEP) ? 0 : duty-STEP.
REQ-022 duty_upd SHALL NOT assert when a step leaves duty unchanged (already at the limit).
REQ-023 up_press and dn_press in the same IDLE cycle SHALL set duty = DUTY_INIT, keep the FSM in IDLE and assert duty_upd only if duty changed.
REQ-024 In HOLD_x, after exactly HOLD_MS*FREQ*1000 clocks from entry with the key still held, the FSM SHALL step once and enter RPT_x.
REQ-025 In RPT_x, the FSM SHALL step every REPEAT_MS*FREQ*1000 clocks while the key is held.
REQ-026 The held key's level going 1 in any HOLD/RPT state SHALL return the FSM to IDLE next cycle with no further step.
REQ-027 Presses of either key outside IDLE SHALL be ignored; they are not queued.
REQ-028 The ms timebase SHALL clear on every entry to HOLD_x or RPT_x so timing is exact, not ±1 ms.
REQ-029 at_max and at_min SHALL be registered and consistent with duty in the same cycle.

Reset
REQ-030 rst_n low SHALL asynchronously force duty=DUTY_INIT, duty_upd=0, state IDLE, timers 0, and at_max/at_min matching DUTY_INIT.
REQ-031 Reset asserted mid-hold SHALL abandon the hold; after release, a key still held SHALL NOT step until a new press pulse arrives.

Configuration
REQ-032 Macro PWM_CTRL_AUTOREPEAT_EN defined: HOLD/RPT timing as above; undefined: the FSM SHALL wait in HOLD_x until release, never enter RPT_x, and omit the ms timebase.

Structure
REQ-033 Package pwm_ctrl_pkg SHALL hold the FSM state enum and the CLKS_PER_MS(FREQ) constant function.
REQ-034 The ms tick SHALL be sub-module ms_tick_gen (inputs clk, rst_n, clr; output tick, one pulse per FREQ*1000 clocks).

Verification (bench: FREQ=1, HOLD_MS=3, REPEAT_MS=2, STEP=8, DUTY_INIT=128)
REQ-035 Reset release, then up_press pulse at cycle 10 -> duty=136 and duty_upd=1 at cycle 11, held 0 after.
REQ-036 duty=250, up_press -> duty=255, at_max=1; a second press -> no duty_upd.
REQ-037 up held 3000 clocks from press -> step to 144 at clock 3000, then 152 at 5000, 160 at 7000; release -> no further steps.
REQ-038 up_press and dn_press in the same cycle with duty=96 -> duty=128, duty_upd=1, state IDLE.
REQ-039 dn held, dn_press pulse while in HOLD_DN, rst_n pulsed low at clock 1500 -> duty=128 immediately, no step after reset while dn stays held.
REQ-040 With PWM_CTRL_AUTOREPEAT_EN undefined, up held 10000 clocks -> exactly one step (136).
